// File: rtl/core_sequencer.sv
// Multi-cycle sequencer for the shared core datapath (FETCH/DECODE/EXEC/MEM/WB).
// Latency: outputs decode combinationally from state and mem_ready; state advances each clk edge.
// Backpressure: waits in FETCH/MEM for mem_ready, traps after TIMEOUT idle cycles; TRAP exits only on rst.
module core_sequencer #(
    parameter int TIMEOUT = 15,
    parameter int TO_W    = 4,
    parameter int CNT_W   = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             run,
    input  logic             mem_ready,
    input  logic             reg_write,
    input  logic             mem_write,
    input  logic             mem_read,
    input  logic [2:0]       branch_src,
    input  logic             jump_src,
    input  logic             jalr_src,
    output logic             mem_req,
    output logic             mem_we,
    output logic             addr_sel,
    output logic             ir_we,
    output logic             mdr_we,
    output logic             rf_we,
    output logic             pc_we,
    output logic             retired,
    output logic             trap,
    output logic [2:0]       state,
    output logic [CNT_W-1:0] retire_cnt
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
        S_WB     = 3'd5,
        S_TRAP   = 3'd6,
        S_BAD    = 3'd7
    } state_t;

    state_t            state_q, state_d;
    logic [TO_W-1:0]   to_q, to_d;
    logic [CNT_W-1:0]  retire_cnt_q, retire_cnt_d;

    // jal/jalr always assert reg_write, so the sequencer needs no separate path for them.
    logic unused_jump;
    assign unused_jump = jump_src ^ jalr_src;

    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);

    // State, timeout counter and retired-instruction counter registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            to_q         <= '0;
            retire_cnt_q <= '0;
        end else begin
            state_q      <= state_d;
            to_q         <= to_d;
            retire_cnt_q <= retire_cnt_d;
        end
    end

    // Next-state, timeout and output decode.
    always_comb begin
        state_d  = state_q;
        to_d     = to_q;
        mem_req  = 1'b0;
        mem_we   = 1'b0;
        addr_sel = 1'b0;
        ir_we    = 1'b0;
        mdr_we   = 1'b0;
        rf_we    = 1'b0;
        pc_we    = 1'b0;
        retired  = 1'b0;
        trap     = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (run) state_d = S_FETCH;
            end
            S_FETCH: begin
                mem_req = 1'b1;
                ir_we   = mem_ready;
                if (mem_ready) begin
                    to_d    = '0;
                    state_d = S_DECODE;
                end else if (to_q == TO_LAST) begin
                    state_d = S_TRAP;
                end else begin
                    to_d = to_q + 1'b1;
                end
            end
            S_DECODE: begin
                if (!reg_write && !mem_write && !mem_read && (branch_src == 3'd0))
                    state_d = S_TRAP;
                else
                    state_d = S_EXEC;
            end
            S_EXEC: begin
                if (mem_read || mem_write) begin
                    state_d = S_MEM;
                end else if (reg_write) begin
                    state_d = S_WB;
                end else begin
                    // Branch: the datapath picks taken/not-taken target on pc_we.
                    pc_we   = 1'b1;
                    retired = 1'b1;
                    state_d = run ? S_FETCH : S_IDLE;
                end
            end
            S_MEM: begin
                mem_req  = 1'b1;
                addr_sel = 1'b1;
                mem_we   = mem_write;
                if (mem_ready) begin
                    to_d = '0;
                    if (mem_read) begin
                        mdr_we  = 1'b1;
                        state_d = S_WB;
                    end else begin
                        pc_we   = 1'b1;
                        retired = 1'b1;
                        state_d = run ? S_FETCH : S_IDLE;
                    end
                end else if (to_q == TO_LAST) begin
                    state_d = S_TRAP;
                end else begin
                    to_d = to_q + 1'b1;
                end
            end
            S_WB: begin
                rf_we   = 1'b1;
                pc_we   = 1'b1;
                retired = 1'b1;
                state_d = run ? S_FETCH : S_IDLE;
            end
            default: begin
                // TRAP, and the unused code 7 behaves identically.
                trap    = 1'b1;
                state_d = S_TRAP;
            end
        endcase

        // Each new memory access starts with a fresh wait budget.
        if ((state_d != state_q) && ((state_d == S_FETCH) || (state_d == S_MEM)))
            to_d = '0;

        retire_cnt_d = retire_cnt_q + CNT_W'(retired);
    end

    assign state      = state_q;
    assign retire_cnt = retire_cnt_q;

endmodule

// File: tb/tb_core_sequencer.sv
module tb_core_sequencer;

    logic        clk = 1'b0;
    logic        rst, run, mem_ready;
    logic        reg_write, mem_write, mem_read, jump_src, jalr_src;
    logic [2:0]  branch_src;
    logic        mem_req, mem_we, addr_sel, ir_we, mdr_we, rf_we, pc_we, retired, trap;
    logic [2:0]  state;
    logic [31:0] retire_cnt;

    int total = 0;
    int passed = 0;

    core_sequencer #(.TIMEOUT(15), .TO_W(4), .CNT_W(32)) dut (
        .clk(clk), .rst(rst), .run(run), .mem_ready(mem_ready),
        .reg_write(reg_write), .mem_write(mem_write), .mem_read(mem_read),
        .branch_src(branch_src), .jump_src(jump_src), .jalr_src(jalr_src),
        .mem_req(mem_req), .mem_we(mem_we), .addr_sel(addr_sel), .ir_we(ir_we),
        .mdr_we(mdr_we), .rf_we(rf_we), .pc_we(pc_we), .retired(retired),
        .trap(trap), .state(state), .retire_cnt(retire_cnt)
    );

    always #5 clk = ~clk;

    // {mem_req, mem_we, addr_sel, ir_we, mdr_we, rf_we, pc_we, retired, trap}
    function automatic logic [8:0] outs();
        return {mem_req, mem_we, addr_sel, ir_we, mdr_we, rf_we, pc_we, retired, trap};
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        else passed++;
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic set_dec(input logic rw, input logic mw, input logic mrd, input logic [2:0] br);
        reg_write = rw; mem_write = mw; mem_read = mrd; branch_src = br;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    typedef struct {
        logic       run, mr, rw, mw, mrd;
        logic [2:0] br;
        logic [2:0] st;
        logic [8:0] out;
    } vec_t;

    function automatic vec_t mk(input logic run_i, input logic mr_i, input logic rw_i,
                                input logic mw_i, input logic mrd_i, input logic [2:0] br_i,
                                input logic [2:0] st_i, input logic [8:0] out_i);
        vec_t v;
        v.run = run_i; v.mr = mr_i; v.rw = rw_i; v.mw = mw_i; v.mrd = mrd_i;
        v.br = br_i; v.st = st_i; v.out = out_i;
        return v;
    endfunction

    vec_t vecs[21];

    initial begin
        int model_cnt;

        rst = 1'b0; run = 1'b0; mem_ready = 1'b0;
        jump_src = 1'b0; jalr_src = 1'b0;
        set_dec(0, 0, 0, 3'd0);
        @(negedge clk);

        // ---------------- reset state ----------------
        do_reset();
        #1;
        chk("reset_state", 32'(state), 32'd0);
        chk("reset_outs", 32'(outs()), 32'd0);
        chk("reset_cnt", retire_cnt, 32'd0);

        // ---------------- table: add, load with waits, store, beq ----------------
        vecs[0]  = mk(1, 1, 1, 0, 0, 3'd0, 3'd0, 9'b000000000); // IDLE
        vecs[1]  = mk(1, 1, 1, 0, 0, 3'd0, 3'd1, 9'b100100000); // add F
        vecs[2]  = mk(1, 1, 1, 0, 0, 3'd0, 3'd2, 9'b000000000); // D
        vecs[3]  = mk(1, 1, 1, 0, 0, 3'd0, 3'd3, 9'b000000000); // E
        vecs[4]  = mk(1, 1, 1, 0, 0, 3'd0, 3'd5, 9'b000001110); // W
        vecs[5]  = mk(1, 1, 1, 0, 1, 3'd0, 3'd1, 9'b100100000); // load F
        vecs[6]  = mk(1, 0, 1, 0, 1, 3'd0, 3'd2, 9'b000000000); // D
        vecs[7]  = mk(1, 1, 1, 0, 1, 3'd0, 3'd3, 9'b000000000); // E (mem_ready ignored)
        vecs[8]  = mk(1, 0, 1, 0, 1, 3'd0, 3'd4, 9'b101000000); // M wait
        vecs[9]  = mk(1, 0, 1, 0, 1, 3'd0, 3'd4, 9'b101000000);
        vecs[10] = mk(1, 0, 1, 0, 1, 3'd0, 3'd4, 9'b101000000);
        vecs[11] = mk(1, 1, 1, 0, 1, 3'd0, 3'd4, 9'b101010000); // M ready
        vecs[12] = mk(1, 1, 1, 0, 1, 3'd0, 3'd5, 9'b000001110); // W
        vecs[13] = mk(1, 1, 0, 1, 0, 3'd0, 3'd1, 9'b100100000); // store F
        vecs[14] = mk(1, 1, 0, 1, 0, 3'd0, 3'd2, 9'b000000000);
        vecs[15] = mk(1, 1, 0, 1, 0, 3'd0, 3'd3, 9'b000000000);
        vecs[16] = mk(1, 1, 0, 1, 0, 3'd0, 3'd4, 9'b111000110); // store retires in M
        vecs[17] = mk(1, 1, 0, 0, 0, 3'd1, 3'd1, 9'b100100000); // beq F
        vecs[18] = mk(1, 1, 0, 0, 0, 3'd1, 3'd2, 9'b000000000);
        vecs[19] = mk(0, 1, 0, 0, 0, 3'd1, 3'd3, 9'b000000110); // beq retires, run low
        vecs[20] = mk(0, 1, 0, 0, 0, 3'd0, 3'd0, 9'b000000000); // IDLE
        for (int i = 0; i < 21; i++) begin
            run = vecs[i].run; mem_ready = vecs[i].mr;
            set_dec(vecs[i].rw, vecs[i].mw, vecs[i].mrd, vecs[i].br);
            #1;
            chk($sformatf("vec%0d", i), {20'd0, state, outs()}, {20'd0, vecs[i].st, vecs[i].out});
            step();
            if (i == 4) chk("cnt_after_add", retire_cnt, 32'd1);
        end
        chk("cnt_after_table", retire_cnt, 32'd4);

        // ---------------- illegal opcode -> sticky trap ----------------
        do_reset();
        run = 1; mem_ready = 1; set_dec(0, 0, 0, 3'd0);
        step(); step(); step();
        #1;
        chk("illegal_state", 32'(state), 32'd6);
        chk("illegal_trap", 32'(outs()), 32'd1);
        for (int i = 0; i < 20; i++) begin
            mem_ready = i[0];
            step();
            #1;
            chk($sformatf("trap_hold%0d", i), {20'd0, state, outs()}, {20'd0, 3'd6, 9'b1});
        end
        do_reset();
        run = 0;
        #1;
        chk("trap_rst_state", 32'(state), 32'd0);
        chk("trap_rst_trap", 32'(trap), 32'd0);
        chk("trap_rst_cnt", retire_cnt, 32'd0);

        // ---------------- FETCH timeout ----------------
        do_reset();
        run = 1; mem_ready = 0; set_dec(1, 0, 0, 3'd0);
        step();
        for (int i = 0; i < 15; i++) begin
            #1;
            chk($sformatf("fetch_wait%0d", i), {28'd0, state, mem_req}, {28'd0, 3'd1, 1'b1});
            step();
        end
        #1;
        chk("fetch_timeout_trap", 32'(state), 32'd6);

        // ready on the 15th waiting cycle is success
        do_reset();
        run = 1; mem_ready = 0;
        step();
        for (int i = 0; i < 14; i++) step();
        mem_ready = 1;
        #1;
        chk("fetch_last_ir_we", 32'(ir_we), 32'd1);
        step();
        #1;
        chk("fetch_last_ok", 32'(state), 32'd2);

        // ---------------- MEM timeout ----------------
        do_reset();
        run = 1; mem_ready = 1; set_dec(1, 0, 1, 3'd0);
        step(); step(); step(); step();
        mem_ready = 0;
        for (int i = 0; i < 15; i++) begin
            #1;
            chk($sformatf("mem_wait%0d", i), 32'(state), 32'd4);
            step();
        end
        #1;
        chk("mem_timeout_trap", 32'(state), 32'd6);

        // ---------------- run dropped mid-instruction ----------------
        do_reset();
        run = 1; mem_ready = 1; set_dec(1, 0, 0, 3'd0);
        step(); step(); step();
        run = 0;
        #1;
        chk("rundrop_exec", 32'(state), 32'd3);
        step();
        #1;
        chk("rundrop_wb", {28'd0, state, retired}, {28'd0, 3'd5, 1'b1});
        step();
        for (int i = 0; i < 4; i++) begin
            #1;
            chk($sformatf("rundrop_idle%0d", i), {28'd0, state, mem_req}, {28'd0, 3'd0, 1'b0});
            step();
        end
        run = 1;
        step();
        #1;
        chk("rundrop_resume", 32'(state), 32'd1);

        // ---------------- reset during MEM ----------------
        do_reset();
        run = 1; mem_ready = 1; set_dec(1, 0, 1, 3'd0);
        step(); step(); step(); step();
        mem_ready = 0;
        #1;
        chk("rstmem_req_before", 32'(mem_req), 32'd1);
        do_reset();
        #1;
        chk("rstmem_after", {28'd0, state, mem_req}, {28'd0, 3'd0, 1'b0});

        // ---------------- randomized stream vs latency model ----------------
        do_reset();
        run = 1; mem_ready = 0;
        model_cnt = 0;
        step();
        for (int k = 0; k < 60; k++) begin
            int kind, fw, mw, lat, cyc, req, n;
            bit done;
            kind = $urandom_range(0, 4);
            fw = ($urandom_range(0, 7) == 0) ? 14 : $urandom_range(0, 3);
            mw = ($urandom_range(0, 7) == 0) ? 14 : $urandom_range(0, 3);
            jalr_src = 0;
            case (kind)
                0: set_dec(1, 0, 0, 3'd0);
                1: set_dec(1, 0, 1, 3'd0);
                2: set_dec(0, 1, 0, 3'd0);
                3: set_dec(0, 0, 0, 3'($urandom_range(1, 7)));
                default: begin set_dec(1, 0, 0, 3'd0); jalr_src = 1; end
            endcase
            lat = (fw + 1) + 2;
            if (kind == 1 || kind == 2) lat += mw + 1;
            if (kind == 0 || kind == 1 || kind == 4) lat += 1;
            cyc = 0; req = 0; n = 0; done = 0;
            while (!done && cyc < 200) begin
                if (mem_req) mem_ready = (n == ((req == 0) ? fw : mw));
                else mem_ready = 1'($urandom_range(0, 1));
                #1;
                if (trap) break;
                if (mem_req && mem_ready) begin req++; n = 0; end
                else if (mem_req) n++;
                cyc++;
                if (retired) done = 1;
                step();
            end
            model_cnt++;
            chk($sformatf("rand%0d_latency", k), cyc, lat);
            chk($sformatf("rand%0d_cnt", k), retire_cnt, model_cnt);
            if (!done) break;
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/core_sequencer.md
Name: core_sequencer

Overview:
- Multi-cycle sequencer driving the shared core datapath: one instruction/data memory port, register file, PC and IR.
- Consumes the combinational decode outputs of the control decoder for the instruction held in IR.
- Steps each instruction through FETCH/DECODE/EXEC/MEM/WB, issuing memory requests and register/PC write enables.
- Traps on illegal opcodes and on memory timeout.

Parameters:
TIMEOUT, 15, maximum wait cycles for mem_ready in FETCH or MEM before trapping (1..2^TO_W-1)
TO_W, 4, width of the timeout counter
CNT_W, 32, width of the retired-instruction counter

Ports:
clk  input  1  single core clock; all state updates on rising edge
rst  input  1  synchronous, active-high reset
run  input  1  start/continue execution; sampled only at instruction boundaries
mem_ready  input  1  memory completes the current request this cycle
reg_write  input  1  from decoder
mem_write  input  1  from decoder
mem_read  input  1  from decoder
branch_src  input  3  from decoder; nonzero = conditional branch
jump_src  input  1  from decoder (jal)
jalr_src  input  1  from decoder (jalr)
mem_req  output  1  memory request valid
mem_we  output  1  request is a write (meaningful only with mem_req)
addr_sel  output  1  0 = PC address, 1 = ALU result address
ir_we  output  1  latch fetched word into IR
mdr_we  output  1  latch load data into MDR
rf_we  output  1  register-file write enable
pc_we  output  1  PC update (datapath selects PC+4/branch/jump target)
retired  output  1  one-cycle pulse per completed instruction
trap  output  1  sticky error flag
state  output  3  current state encoding
retire_cnt  output  CNT_W  count of retired instructions, wraps modulo 2^CNT_W

Behaviour:
- State register encoding: IDLE=0, FETCH=1, DECODE=2, EXEC=3, MEM=4, WB=5, TRAP=6; code 7 unreachable, treated as TRAP.
- Outputs are decoded combinationally from state plus mem_ready. Only state, the timeout counter and retire_cnt are registered.
- Reset: on a clock edge with rst=1, state→IDLE, timeout counter→0, retire_cnt→0, trap cleared. All outputs are 0 in IDLE.
- Reset overrides everything, including mid-access. mem_req drops the cycle after the reset edge; the in-flight access is abandoned.
- IDLE: all outputs 0. If run=1, next state is FETCH.
- FETCH: mem_req=1, addr_sel=0, mem_we=0. ir_we=mem_ready.
  - mem_ready=1: next state DECODE.
  - Otherwise the timeout counter increments. When it reaches TIMEOUT with mem_ready still 0, next state is TRAP.
- DECODE: one cycle, no enables.
  - Illegal when reg_write, mem_write, mem_read and branch_src are all 0: next state TRAP.
  - Otherwise next state EXEC.
- EXEC: one cycle. Priority order:
  - mem_read or mem_write → MEM.
  - reg_write (ALU, lui, auipc, jal, jalr) → WB.
  - Otherwise (branch): pc_we=1, retired=1, next state FETCH if run else IDLE.
- MEM: mem_req=1, addr_sel=1, mem_we=mem_write.
  - On mem_ready with a load: mdr_we=1, next state WB.
  - On mem_ready with a store: pc_we=1, retired=1, next state FETCH if run else IDLE.
  - Timeout rule identical to FETCH.
- WB: rf_we=1, pc_we=1, retired=1, next state FETCH if run else IDLE.
- TRAP: trap=1, all other enables 0. Only rst exits.
- Timeout counter: cleared on every transition into FETCH or MEM and on mem_ready=1; holds in other states.
- retire_cnt increments on every cycle with retired=1 and wraps from all-ones to 0.
- Boundary conditions:
  - mem_ready outside FETCH/MEM is ignored.
  - run falling mid-instruction does not abort; the instruction completes, then the sequencer enters IDLE.
  - mem_ready=1 on the exact cycle the counter reaches TIMEOUT counts as success, not a trap.
- Latency with zero-wait memory (mem_ready=1 on the first request cycle):
  - ALU/lui/auipc/jal/jalr: 4 cycles (F,D,E,W).
  - Load: 5 cycles (F,D,E,M,W).
  - Store: 4 cycles (F,D,E,M).
  - Branch: 3 cycles (F,D,E).

Test Plan:
- Reset, then run=1, mem_ready tied 1, add decode (reg_write=1) → state sequence 0,1,2,3,5,1; rf_we, pc_we and retired high only in WB; retire_cnt=1 after 4 cycles.
- Load (mem_read=1, reg_write=1); mem_ready low for 3 MEM cycles → mem_req=1, addr_sel=1, mem_we=0 for 4 MEM cycles; mdr_we pulses with mem_ready; then WB; total 8 cycles.
- Store then beq (branch_src=001), zero-wait → store retires from MEM with mem_we=1, pc_we=1; beq retires from EXEC 3 cycles later; retire_cnt=2.
- All decoder inputs 0 in DECODE → state 6, trap=1 next cycle; stays 6 for 20 cycles with mem_ready toggling; rst=1 for one edge → state 0, trap=0, retire_cnt=0.
- TIMEOUT=15, mem_ready held 0 in FETCH → TRAP entered after 15 waiting cycles. Repeat with mem_ready=1 on the 15th cycle → DECODE, no trap.
- run dropped during EXEC of an ALU instruction → WB completes with retired=1, then IDLE; mem_req stays 0 until run=1. Assert rst during MEM → mem_req=0 the cycle after the reset edge.
